// File: rtl/plab4_net_router_input_ctrl_tp.sv
// Input-port control for one ring router with timing-channel protection.
// Routes the head message to an output request vector. Accepts the message
// only when a requested output grants and this port's domain owns the slot.
// The block is purely combinational. clk/reset exist only for port uniformity.

module plab4_net_router_input_ctrl_tp #(
    parameter int unsigned p_router_id    = 0,
    parameter int unsigned p_num_routers  = 8,
    parameter logic [2:0]  p_default_reqs = 3'b001,
    parameter int unsigned domain         = 0,
    localparam int unsigned c_dest_nbits  = $clog2(p_num_routers)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [c_dest_nbits-1:0] dest,
    input  logic                    in_val,
    output logic                    in_rdy,
    output logic [2:0]              reqs,
    input  logic [2:0]              grants,
    input  logic                    domain0,
    input  logic                    domain1
);

    localparam logic [2:0] c_local_reqs = 3'b010;
    localparam logic [c_dest_nbits-1:0] c_router_id = c_dest_nbits'(p_router_id);

    logic [2:0] route;
    logic       my_slot;
    logic       granted;

    // clk/reset are carried for port uniformity and drive nothing
    logic unused_clk_reset;
    assign unused_clk_reset = ^{clk, reset};

    // Local destinations eject at the terminal port. Everything else takes
    // the fixed pass-through direction.
    always_comb begin
        route = p_default_reqs;
        if (dest == c_router_id) begin
            route = c_local_reqs;
        end
    end

    // Pick the slot-ownership signal for this port's domain and ignore the other one
    always_comb begin
        my_slot = domain0;
        if (domain != 0) begin
            my_slot = domain1;
        end
    end

    // Requests are raised whenever a message is valid. Acceptance also needs
    // a grant on a requested port and ownership of the current slot. When
    // in_val is low, the outputs are forced to zero through the ternary so
    // that unknown inputs cannot leak through.
    always_comb begin
        reqs    = in_val ? route : 3'b000;
        granted = |(reqs & grants);
        in_rdy  = in_val ? (granted & my_slot) : 1'b0;
    end

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_tp.sv
// Directed table-driven bench for the router input control block.
// Four instances share the same inputs:
//   0: router 2, domain 0
//   1: router 2, domain 1
//   2: router 0, domain 0
//   3: router 7, domain 0

module tb_plab4_net_router_input_ctrl_tp;

    logic       clk;
    logic       reset;
    logic [2:0] dest;
    logic       in_val;
    logic [2:0] grants;
    logic       domain0;
    logic       domain1;

    logic       rdy0, rdy1, rdy2, rdy3;
    logic [2:0] reqs0, reqs1, reqs2, reqs3;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [1:0] inst;
        logic       in_val;
        logic [2:0] dest;
        logic [2:0] grants;
        logic       d0;
        logic       d1;
        logic [2:0] exp_reqs;
        logic       exp_rdy;
    } vec_t;

    plab4_net_router_input_ctrl_tp #(.p_router_id(2), .p_num_routers(8), .p_default_reqs(3'b001), .domain(0)) dut_d0 (
        .clk(clk), .reset(reset), .dest(dest), .in_val(in_val), .in_rdy(rdy0),
        .reqs(reqs0), .grants(grants), .domain0(domain0), .domain1(domain1));

    plab4_net_router_input_ctrl_tp #(.p_router_id(2), .p_num_routers(8), .p_default_reqs(3'b001), .domain(1)) dut_d1 (
        .clk(clk), .reset(reset), .dest(dest), .in_val(in_val), .in_rdy(rdy1),
        .reqs(reqs1), .grants(grants), .domain0(domain0), .domain1(domain1));

    plab4_net_router_input_ctrl_tp #(.p_router_id(0), .p_num_routers(8), .p_default_reqs(3'b001), .domain(0)) dut_r0 (
        .clk(clk), .reset(reset), .dest(dest), .in_val(in_val), .in_rdy(rdy2),
        .reqs(reqs2), .grants(grants), .domain0(domain0), .domain1(domain1));

    plab4_net_router_input_ctrl_tp #(.p_router_id(7), .p_num_routers(8), .p_default_reqs(3'b001), .domain(0)) dut_r7 (
        .clk(clk), .reset(reset), .dest(dest), .in_val(in_val), .in_rdy(rdy3),
        .reqs(reqs3), .grants(grants), .domain0(domain0), .domain1(domain1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic v, input logic [2:0] d, input logic [2:0] g,
                         input logic a0, input logic a1);
        in_val  = v;
        dest    = d;
        grants  = g;
        domain0 = a0;
        domain1 = a1;
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] inst,
                         input logic [2:0] exp_reqs, input logic exp_rdy);
        logic [2:0] act_reqs;
        logic       act_rdy;
        case (inst)
            2'd0:    begin act_reqs = reqs0; act_rdy = rdy0; end
            2'd1:    begin act_reqs = reqs1; act_rdy = rdy1; end
            2'd2:    begin act_reqs = reqs2; act_rdy = rdy2; end
            default: begin act_reqs = reqs3; act_rdy = rdy3; end
        endcase
        n_checks++;
        if (act_reqs !== exp_reqs) begin
            n_fail++;
            $display("FAIL %s reqs: got %b expected %b", name, act_reqs, exp_reqs);
        end
        n_checks++;
        if (act_rdy !== exp_rdy) begin
            n_fail++;
            $display("FAIL %s in_rdy: got %b expected %b", name, act_rdy, exp_rdy);
        end
    endtask

    vec_t vecs[$];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;

        //                inst  v  dest    grants  d0 d1 reqs    rdy
        vecs.push_back('{2'd0, 1, 3'd1, 3'b000, 1, 0, 3'b001, 0}); // no grant
        vecs.push_back('{2'd0, 1, 3'd1, 3'b001, 1, 0, 3'b001, 1}); // granted
        vecs.push_back('{2'd0, 1, 3'd1, 3'b110, 1, 0, 3'b001, 0}); // unrequested grants
        vecs.push_back('{2'd0, 1, 3'd3, 3'b001, 1, 0, 3'b001, 1});
        vecs.push_back('{2'd0, 1, 3'd5, 3'b111, 1, 0, 3'b001, 1});
        vecs.push_back('{2'd0, 1, 3'd7, 3'b101, 1, 0, 3'b001, 1});
        vecs.push_back('{2'd0, 1, 3'd1, 3'b001, 0, 1, 3'b001, 0}); // wrong slot
        vecs.push_back('{2'd0, 1, 3'd3, 3'b001, 0, 1, 3'b001, 0});
        vecs.push_back('{2'd0, 1, 3'd7, 3'b001, 0, 1, 3'b001, 0});
        vecs.push_back('{2'd0, 1, 3'd2, 3'b010, 1, 0, 3'b010, 1}); // local eject
        vecs.push_back('{2'd0, 1, 3'd2, 3'b111, 1, 0, 3'b010, 1});
        vecs.push_back('{2'd0, 1, 3'd2, 3'b101, 1, 0, 3'b010, 0});
        vecs.push_back('{2'd0, 1, 3'd2, 3'b010, 0, 1, 3'b010, 0});
        vecs.push_back('{2'd0, 0, 3'd2, 3'b111, 1, 1, 3'b000, 0}); // invalid
        vecs.push_back('{2'd0, 1, 3'd1, 3'b001, 1, 1, 3'b001, 1}); // both slots high
        vecs.push_back('{2'd0, 1, 3'd1, 3'b001, 0, 0, 3'b001, 0}); // both slots low
        vecs.push_back('{2'd1, 1, 3'd1, 3'b001, 0, 1, 3'b001, 1}); // domain 1 port
        vecs.push_back('{2'd1, 1, 3'd1, 3'b001, 1, 0, 3'b001, 0});
        vecs.push_back('{2'd1, 1, 3'd1, 3'b001, 1, 1, 3'b001, 1});
        vecs.push_back('{2'd1, 1, 3'd2, 3'b010, 0, 1, 3'b010, 1});
        vecs.push_back('{2'd2, 1, 3'd0, 3'b010, 1, 0, 3'b010, 1}); // ring extreme 0
        vecs.push_back('{2'd2, 1, 3'd7, 3'b001, 1, 0, 3'b001, 1});
        vecs.push_back('{2'd3, 1, 3'd7, 3'b010, 1, 0, 3'b010, 1}); // ring extreme 7
        vecs.push_back('{2'd3, 1, 3'd0, 3'b001, 1, 0, 3'b001, 1});

        @(negedge clk);
        foreach (vecs[i]) begin
            apply(vecs[i].in_val, vecs[i].dest, vecs[i].grants, vecs[i].d0, vecs[i].d1);
            check($sformatf("vec%0d", i), vecs[i].inst, vecs[i].exp_reqs, vecs[i].exp_rdy);
        end

        // Invalid input with arbitrary don't-care values on every other input
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 3'($urandom_range(7)), 3'($urandom_range(7)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            for (int k = 0; k < 4; k++) begin
                check($sformatf("inval%0d_inst%0d", i, k), 2'(k), 3'b000, 1'b0);
            end
        end

        // Outputs stay steady across clock edges and reset assertion
        apply(1'b1, 3'd1, 3'b001, 1'b1, 1'b0);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_pass", 2'd0, 3'b001, 1'b1);
        end
        apply(1'b1, 3'd2, 3'b010, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("rst_local_d0", 2'd0, 3'b010, 1'b0);
        check("rst_local_d1", 2'd1, 3'b010, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_d1", 2'd1, 3'b010, 1'b1);
        apply(1'b0, 3'd2, 3'b111, 1'b1, 1'b1);
        @(negedge clk); #1;
        check("negedge_inval", 2'd0, 3'b000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
